// File: rtl/alu_defs.sv
// Opcodes shared with the ALU decoder, plus the multiply/divide sequencer state encoding.
package alu_defs;

    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring, on magnitudes).
// One bit per cycle; the result lands in a registered RZ with a one-cycle done strobe.
module muldiv_unit
    import alu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4:0]           opcode,
    input  logic [WIDTH-1:0]     RA,
    input  logic [WIDTH-1:0]     RB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   RZ,
    output logic                 div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    md_state_e            state_q;
    logic [CW-1:0]        cnt_q;
    logic                 is_div_q, dz_q, qneg_q, rneg_q, qm1_q;
    logic                 busy_q, done_q, dbz_q;
    logic [2*WIDTH-1:0]   rz_q;
    // a_q carries one guard bit so Booth subtracting -2^(W-1) cannot overflow,
    // and so the restoring trial subtract has a sign bit.
    logic [WIDTH:0]       a_q, m_q;
    logic [WIDTH-1:0]     q_q;

    logic [WIDTH:0]       a_d, sum, sh, trial;
    logic [WIDTH-1:0]     q_d, ra_mag, rb_mag, quo, rem;
    logic                 qm1_d, accept;
    logic [2*WIDTH-1:0]   rz_d;

    assign ra_mag = RA[WIDTH-1] ? -RA : RA;
    assign rb_mag = RB[WIDTH-1] ? -RB : RB;
    assign accept = start && (opcode == OP_MUL || opcode == OP_DIV);

    always_comb begin
        a_d   = a_q;
        q_d   = q_q;
        qm1_d = qm1_q;
        sum   = a_q;
        sh    = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        trial = sh - m_q;
        if (is_div_q) begin
            a_d = trial[WIDTH] ? sh : trial;
            q_d = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
            case ({q_q[0], qm1_q})
                2'b01:   sum = a_q + m_q;
                2'b10:   sum = a_q - m_q;
                default: sum = a_q;
            endcase
            {a_d, q_d, qm1_d} = {sum[WIDTH], sum, q_q};
        end
        quo  = qneg_q ? -q_d : q_d;
        rem  = rneg_q ? -a_d[WIDTH-1:0] : a_d[WIDTH-1:0];
        rz_d = is_div_q ? {rem, quo} : {a_d[WIDTH-1:0], q_d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            qm1_q    <= 1'b0;
            a_q      <= '0;
            m_q      <= '0;
            q_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            rz_q     <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (accept) begin
                        state_q  <= MD_CALC;
                        busy_q   <= 1'b1;
                        dbz_q    <= 1'b0;
                        cnt_q    <= '0;
                        a_q      <= '0;
                        qm1_q    <= 1'b0;
                        is_div_q <= (opcode == OP_DIV);
                        dz_q     <= (opcode == OP_DIV) && (RB == '0);
                        qneg_q   <= RA[WIDTH-1] ^ RB[WIDTH-1];
                        rneg_q   <= RA[WIDTH-1];
                        if (opcode == OP_DIV) begin
                            // Divide-by-zero keeps the raw dividend for the result.
                            q_q <= (RB == '0) ? RA : ra_mag;
                            m_q <= {1'b0, rb_mag};
                        end else begin
                            q_q <= RB;
                            m_q <= {RA[WIDTH-1], RA};
                        end
                    end
                end
                MD_CALC: begin
                    if (dz_q) begin
                        state_q <= MD_DONE;
                        done_q  <= 1'b1;
                        dbz_q   <= 1'b1;
                        rz_q    <= {q_q, {WIDTH{1'b1}}};
                    end else begin
                        a_q   <= a_d;
                        q_q   <= q_d;
                        qm1_q <= qm1_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            state_q <= MD_DONE;
                            done_q  <= 1'b1;
                            rz_q    <= rz_d;
                        end
                    end
                end
                MD_DONE: begin
                    state_q <= MD_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign RZ          = rz_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: issued operations push expected results into a
// scoreboard; a monitor pops and checks RZ, div_by_zero and latency on each done.
module tb_muldiv_unit;
    import alu_defs::*;

    typedef struct {
        logic [63:0] rz;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  opcode = 5'd0;
    logic [31:0] RA = 32'd0;
    logic [31:0] RB = 32'd0;
    logic        busy, done, div_by_zero;
    logic [63:0] RZ;

    exp_t sb[$];
    int   cyc = 0;
    int   nvec = 0;
    int   nfail = 0;
    int   ndone = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .RA(RA), .RB(RB), .busy(busy), .done(done), .RZ(RZ),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            ndone++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("RZ", RZ, e.rz);
                chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dz});
                chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] rz, input logic dz, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1; opcode = op; RA = a; RB = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        RA = 32'hDEADBEEF; RB = 32'h0BADF00D;
        e.rz = rz; e.dz = dz; e.lat = lat; e.acc = cyc;
        if (push) sb.push_back(e);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) ok = 1'b1;
        end
        chk("completion_timeout", {63'd0, ok}, 64'd1);
    endtask

    initial begin
        int d0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_dbz", {63'd0, div_by_zero}, 64'd0);
        chk("reset_RZ", RZ, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        issue(OP_MUL, 32'd6, -32'sd7, 64'hFFFFFFFF_FFFFFFD6, 1'b0, 32, 1'b1);
        wait_idle();
        issue(OP_MUL, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 32, 1'b1);
        wait_idle();
        issue(OP_MUL, 32'd0, 32'hFFFFFFFF, 64'd0, 1'b0, 32, 1'b1);
        wait_idle();
        issue(OP_DIV, 32'd36, 32'd6, {32'h0, 32'h6}, 1'b0, 32, 1'b1);
        wait_idle();
        issue(OP_DIV, -32'sd7, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, 32, 1'b1);
        wait_idle();
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 1'b0, 32, 1'b1);
        wait_idle();

        issue(OP_DIV, 32'd5, 32'd0, {32'h5, 32'hFFFFFFFF}, 1'b1, 1, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("dbz_held", {63'd0, div_by_zero}, 64'd1);
        chk("RZ_held", RZ, {32'h5, 32'hFFFFFFFF});
        issue(OP_MUL, 32'd2, 32'd3, 64'd6, 1'b0, 32, 1'b1);
        wait_idle();

        issue(OP_DIV, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 32, 1'b1);
        repeat (10) @(negedge clk);
        start = 1'b1; opcode = OP_MUL; RA = 32'd9; RB = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        @(negedge clk);
        start = 1'b1; opcode = 5'b00000; RA = 32'd1; RB = 32'd1;
        @(negedge clk);
        start = 1'b0;
        chk("bad_opcode_busy", {63'd0, busy}, 64'd0);

        d0 = ndone;
        issue(OP_MUL, 32'd7, 32'd9, 64'd63, 1'b0, 32, 1'b0);
        repeat (14) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_dbz", {63'd0, div_by_zero}, 64'd0);
        chk("abort_RZ", RZ, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 64'(ndone - d0), 64'd0);

        issue(OP_MUL, -32'sd3, -32'sd5, 64'd15, 1'b0, 32, 1'b1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
